// File: rtl/vga_fb_pkg.sv
// Shared VGA/framebuffer constants and the page-flip controller state encoding.
package vga_fb_pkg;

  localparam int unsigned FB_W     = 256;
  localparam int unsigned FB_H     = 192;
  localparam int unsigned FB_SIZE  = FB_W * FB_H;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VB = 2'd1,
    ST_CLEAR   = 2'd2,
    ST_DONE    = 2'd3
  } swap_state_e;

endpackage

// File: rtl/vga_vblank_detect.sv
// Registered one-cycle strobe marking the start of vertical blanking
// (the cycle after x==0 && y==V_LINE is sampled).
module vga_vblank_detect
  import vga_fb_pkg::*;
#(
  parameter int unsigned V_LINE = V_ACTIVE
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic       vb_start_o
);

  logic vb_start_q;

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      vb_start_q <= 1'b0;
    end else begin
      vb_start_q <= (x_i == 10'd0) && (y_i == 10'(V_LINE));
    end
  end

  assign vb_start_o = vb_start_q;

endmodule

// File: rtl/fb_swap_controller.sv
// Double-buffer page-flip controller: swaps scanout/render bases at vblank start
// and optionally fills the new back buffer through a request/ack write port.
module fb_swap_controller #(
  parameter int unsigned ADDR_W    = 17,
  parameter int unsigned FB_SIZE   = 49152,
  parameter int unsigned BUF0_BASE = 0,
  parameter int unsigned BUF1_BASE = 49152,
  parameter int unsigned V_ACTIVE  = 480
) (
  input  logic              clk25,
  input  logic              rst_n,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              swap_req,
  input  logic              clear_en,
  input  logic [7:0]        clear_color,
  output logic              swap_busy,
  output logic              swap_done,
  output logic [ADDR_W-1:0] front_base,
  output logic [ADDR_W-1:0] back_base,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ack
);

  import vga_fb_pkg::*;

  swap_state_e       state_q;
  logic [ADDR_W-1:0] front_q;
  logic [ADDR_W-1:0] back_q;
  logic              busy_q;
  logic              done_q;
  logic              wr_req_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              clr_en_q;
  logic [7:0]        color_q;
  logic              vb_start;
  logic [CNT_W-1:0]  cnt_nxt;

  vga_vblank_detect #(
    .V_LINE (V_ACTIVE)
  ) u_vblank (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .x_i        (x),
    .y_i        (y),
    .vb_start_o (vb_start)
  );

  assign cnt_nxt = cnt_q + CNT_W'(1);

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      front_q   <= ADDR_W'(BUF0_BASE);
      back_q    <= ADDR_W'(BUF1_BASE);
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
      clr_en_q  <= 1'b0;
      color_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (swap_req) begin
            clr_en_q <= clear_en;
            color_q  <= clear_color;
            busy_q   <= 1'b1;
            state_q  <= ST_WAIT_VB;
          end
        end
        ST_WAIT_VB: begin
          if (vb_start) begin
            front_q <= back_q;
            back_q  <= front_q;
            if (clr_en_q) begin
              // Old front becomes the new back buffer; start filling it at offset 0.
              cnt_q     <= '0;
              wr_req_q  <= 1'b1;
              wr_addr_q <= front_q;
              wr_data_q <= color_q;
              state_q   <= ST_CLEAR;
            end else begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_CLEAR: begin
          if (wr_ack) begin
            if (cnt_q == CNT_W'(FB_SIZE - 1)) begin
              wr_req_q <= 1'b0;
              state_q  <= ST_DONE;
            end else begin
              cnt_q     <= cnt_nxt;
              wr_addr_q <= back_q + ADDR_W'(cnt_nxt);
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign swap_busy  = busy_q;
  assign swap_done  = done_q;
  assign front_base = front_q;
  assign back_base  = back_q;
  assign wr_req     = wr_req_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_fb_swap_controller.sv
// Directed bench for fb_swap_controller: flips, clears with stalls, ignored
// requests, vblank-coincident request and reset during a clear.
module tb_fb_swap_controller;

  localparam int unsigned AW  = 17;
  localparam int unsigned FBS = 49152;
  localparam logic [AW-1:0] B0 = 17'd0;
  localparam logic [AW-1:0] B1 = 17'd49152;

  logic          clk25 = 1'b0;
  logic          rst_n;
  logic [9:0]    x;
  logic [9:0]    y;
  logic          swap_req;
  logic          clear_en;
  logic [7:0]    clear_color;
  logic          swap_busy;
  logic          swap_done;
  logic [AW-1:0] front_base;
  logic [AW-1:0] back_base;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_ack;

  int n_assert = 0;
  int n_fail   = 0;
  int nw;
  int bad;

  always #20 clk25 = ~clk25;

  fb_swap_controller dut (
    .clk25       (clk25),
    .rst_n       (rst_n),
    .x           (x),
    .y           (y),
    .swap_req    (swap_req),
    .clear_en    (clear_en),
    .clear_color (clear_color),
    .swap_busy   (swap_busy),
    .swap_done   (swap_done),
    .front_base  (front_base),
    .back_base   (back_base),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk25);
  endtask

  // Present x==0,y==V_ACTIVE for one cycle; vb_start is high during the following cycle.
  task automatic pulse_vb();
    x = 10'd0;
    y = 10'd480;
    tick(1);
    x = 10'd5;
    y = 10'd100;
  endtask

  task automatic run_clear(input logic [AW-1:0] base, input logic [7:0] col,
                           input int rand_writes, input int stop_at, input bit inject,
                           output int nwr);
    int            cyc;
    bit            stalled;
    bit            injected;
    logic [AW-1:0] h_addr;
    logic [7:0]    h_data;
    cyc      = 0;
    stalled  = 1'b0;
    injected = 1'b0;
    h_addr   = '0;
    h_data   = '0;
    nwr      = 0;
    while (nwr < stop_at && cyc < 120000) begin
      wr_ack   = (nwr < rand_writes) ? ($urandom_range(0, 99) < 30) : 1'b1;
      swap_req = 1'b0;
      if (inject && !injected && nwr == 500) begin
        swap_req = 1'b1;
        injected = 1'b1;
      end
      if (wr_req !== 1'b1) begin
        chk("clr_wr_req_high", 32'(wr_req), 32'd1);
        break;
      end
      if (stalled) begin
        chk("hold_addr", 32'(wr_addr), 32'(h_addr));
        chk("hold_data", 32'(wr_data), 32'(h_data));
      end
      if (wr_ack) begin
        chk("wr_addr", 32'(wr_addr), 32'(base) + 32'(nwr));
        chk("wr_data", 32'(wr_data), 32'(col));
        nwr++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        h_addr  = wr_addr;
        h_data  = wr_data;
      end
      tick(1);
      cyc++;
    end
    wr_ack   = 1'b0;
    swap_req = 1'b0;
    if (cyc >= 120000) chk("clr_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; x = 10'd5; y = 10'd100;
    swap_req = 1'b0; clear_en = 1'b0; clear_color = 8'h00; wr_ack = 1'b0;
    tick(3);
    chk("rst_front", 32'(front_base), 32'(B0));
    chk("rst_back", 32'(back_base), 32'(B1));
    chk("rst_busy", 32'(swap_busy), 32'd0);
    chk("rst_done", 32'(swap_done), 32'd0);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;

    // Idle across two vblanks: nothing moves, stray acks are ignored.
    bad = 0;
    for (int f = 0; f < 2; f++) begin
      pulse_vb();
      for (int i = 0; i < 10; i++) begin
        wr_ack = i[0];
        if (wr_req !== 1'b0 || swap_busy !== 1'b0 || swap_done !== 1'b0) bad++;
        tick(1);
      end
    end
    wr_ack = 1'b0;
    chk("idle_quiet", 32'(bad), 32'd0);
    chk("idle_front", 32'(front_base), 32'(B0));
    chk("idle_back", 32'(back_base), 32'(B1));

    // Flip with clear E3; stalls for the first 1500 writes, second request mid-clear.
    clear_en = 1'b1; clear_color = 8'hE3; swap_req = 1'b1;
    tick(1);
    swap_req = 1'b0; clear_en = 1'b0; clear_color = 8'h00;
    chk("clr_busy", 32'(swap_busy), 32'd1);
    tick(5);
    chk("clr_front_pre_vb", 32'(front_base), 32'(B0));
    chk("clr_no_wr_pre_vb", 32'(wr_req), 32'd0);
    pulse_vb();
    tick(1);
    chk("clr_front", 32'(front_base), 32'(B1));
    chk("clr_back", 32'(back_base), 32'(B0));
    run_clear(B0, 8'hE3, 1500, FBS, 1'b1, nw);
    chk("clr_count", 32'(nw), 32'(FBS));
    chk("clr_req_drop", 32'(wr_req), 32'd0);
    chk("clr_done_early", 32'(swap_done), 32'd0);
    tick(1);
    chk("clr_done", 32'(swap_done), 32'd1);
    chk("clr_busy_at_done", 32'(swap_busy), 32'd0);
    tick(1);
    chk("clr_done_1cyc", 32'(swap_done), 32'd0);
    tick(3);
    chk("ign_busy", 32'(swap_busy), 32'd0);
    pulse_vb();
    tick(3);
    chk("ign_front", 32'(front_base), 32'(B1));
    chk("ign_back", 32'(back_base), 32'(B0));
    chk("ign_done", 32'(swap_done), 32'd0);

    // Plain flip requested mid-frame returns front to buffer 0.
    swap_req = 1'b1;
    tick(1);
    swap_req = 1'b0;
    chk("sw_busy", 32'(swap_busy), 32'd1);
    tick(4);
    chk("sw_front_hold", 32'(front_base), 32'(B1));
    pulse_vb();
    chk("sw_front_pre", 32'(front_base), 32'(B1));
    tick(1);
    chk("sw_front", 32'(front_base), 32'(B0));
    chk("sw_back", 32'(back_base), 32'(B1));
    chk("sw_busy_flip", 32'(swap_busy), 32'd1);
    chk("sw_done_early", 32'(swap_done), 32'd0);
    tick(1);
    chk("sw_done", 32'(swap_done), 32'd1);
    chk("sw_busy_done", 32'(swap_busy), 32'd0);
    tick(1);
    chk("sw_done_1cyc", 32'(swap_done), 32'd0);
    chk("sw_no_wr", 32'(wr_req), 32'd0);

    // Request coinciding with vb_start is accepted but waits for the next vblank.
    x = 10'd0; y = 10'd480;
    tick(1);
    x = 10'd5; y = 10'd100; swap_req = 1'b1;
    tick(1);
    swap_req = 1'b0;
    chk("co_busy", 32'(swap_busy), 32'd1);
    tick(3);
    chk("co_no_flip", 32'(front_base), 32'(B0));
    pulse_vb();
    tick(1);
    chk("co_front", 32'(front_base), 32'(B1));
    chk("co_back", 32'(back_base), 32'(B0));
    tick(1);
    chk("co_done", 32'(swap_done), 32'd1);
    tick(1);

    // Clear 5A with random stalls, reset asserted after 1000 writes.
    clear_en = 1'b1; clear_color = 8'h5A; swap_req = 1'b1;
    tick(1);
    swap_req = 1'b0; clear_en = 1'b0;
    pulse_vb();
    tick(1);
    chk("ab_front", 32'(front_base), 32'(B0));
    chk("ab_back", 32'(back_base), 32'(B1));
    run_clear(B1, 8'h5A, 100000, 1000, 1'b0, nw);
    chk("ab_count", 32'(nw), 32'd1000);
    rst_n = 1'b0;
    #1;
    chk("ab_wr_req", 32'(wr_req), 32'd0);
    chk("ab_front_rst", 32'(front_base), 32'(B0));
    chk("ab_back_rst", 32'(back_base), 32'(B1));
    chk("ab_busy", 32'(swap_busy), 32'd0);
    tick(2);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      wr_ack = ($urandom_range(0, 99) < 30);
      if (i == 5) pulse_vb();
      if (swap_done !== 1'b0 || wr_req !== 1'b0 || swap_busy !== 1'b0) bad++;
      tick(1);
    end
    wr_ack = 1'b0;
    chk("ab_quiet", 32'(bad), 32'd0);

    // Normal flip after the abort.
    swap_req = 1'b1;
    tick(1);
    swap_req = 1'b0;
    chk("post_busy", 32'(swap_busy), 32'd1);
    pulse_vb();
    tick(1);
    chk("post_front", 32'(front_base), 32'(B1));
    chk("post_back", 32'(back_base), 32'(B0));
    tick(1);
    chk("post_done", 32'(swap_done), 32'd1);
    tick(1);
    chk("post_done_1cyc", 32'(swap_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
